// File: rtl/lfsr_roller_pkg.sv
// Shared definitions for the LFSR roller.
//   state_t   : roller FSM states (S_IDLE, S_ROLL)
//   lfsr_next : one Fibonacci LFSR step, new MSB = XOR of tapped bits,
//               remaining bits shifted right. Operands are zero-extended to
//               32 bits by the caller; width selects where the feedback lands.
package lfsr_roller_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ROLL = 1'b1
  } state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur,
                                            input logic [31:0] taps,
                                            input int unsigned width);
    logic fb;
    fb = ^(cur & taps);
    return (cur >> 1) | (32'(fb) << (width - 1));
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running LFSR that advances on every rising clock edge.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads RESET_VAL
//   state : current LFSR contents
module lfsr_core
  import lfsr_roller_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS      = 4'b1001,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] seed_r;
  logic [WIDTH-1:0] seed_w;

  always_comb begin
    seed_w = WIDTH'(lfsr_next(32'(seed_r), 32'(TAPS), WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_r <= RESET_VAL;
    end else begin
      seed_r <= seed_w;
    end
  end

  assign state = seed_r;

endmodule

// File: rtl/lfsr_roller.sv
// Dice-style roller: on start, latches the free-running LFSR value and then
// steps the displayed value STEPS times with linearly growing gaps
// (BASE_GAP, 2*BASE_GAP, ...), so the display visibly slows down.
//   i_clk        : clock
//   i_rst_n      : asynchronous active-low reset
//   i_start      : start / restart a roll (wins over i_stop)
//   i_stop       : abort the running roll, freezing the display
//   o_random_out : displayed value
//   o_busy       : high while rolling
//   o_done       : one-cycle pulse when a roll completes or is aborted
module lfsr_roller
  import lfsr_roller_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1001,
  parameter int               STEPS    = 6,
  parameter int               BASE_GAP = 2**23
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_random_out,
  output logic             o_busy,
  output logic             o_done
);

  // The largest gap limit is BASE_GAP*STEPS-1; size so it never wraps.
  localparam int CNT_BITS = $clog2(longint'(BASE_GAP) * longint'(STEPS) + 1);
  localparam int IDX_BITS = $clog2(STEPS + 1);

  logic [WIDTH-1:0]    seed;

  state_t              state_r,  state_w;
  logic [WIDTH-1:0]    out_r,    out_w;
  logic [CNT_BITS-1:0] gap_r,    gap_w;
  logic [IDX_BITS-1:0] step_r,   step_w;
  logic                busy_r,   busy_w;
  logic                done_r,   done_w;
  logic [CNT_BITS-1:0] gap_limit;

  lfsr_core #(
    .WIDTH    (WIDTH),
    .TAPS     (TAPS),
    .RESET_VAL({WIDTH{1'b1}})
  ) u_seed (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .state(seed)
  );

  always_comb begin
    state_w = state_r;
    out_w   = out_r;
    gap_w   = gap_r;
    step_w  = step_r;
    done_w  = 1'b0;
    // Step k fires once the counter has run BASE_GAP*(k+1) cycles.
    gap_limit = CNT_BITS'(BASE_GAP) * CNT_BITS'(step_r + IDX_BITS'(1))
                - CNT_BITS'(1);

    case (state_r)
      S_IDLE: begin
        if (i_start) begin
          out_w   = seed;
          gap_w   = '0;
          step_w  = '0;
          state_w = S_ROLL;
        end
      end
      S_ROLL: begin
        if (i_start) begin
          // Restart outranks abort and any step due this cycle.
          out_w  = seed;
          gap_w  = '0;
          step_w = '0;
        end else if (i_stop) begin
          state_w = S_IDLE;
          gap_w   = '0;
          step_w  = '0;
          done_w  = 1'b1;
        end else if (gap_r == gap_limit) begin
          out_w  = WIDTH'(lfsr_next(32'(out_r), 32'(TAPS), WIDTH));
          gap_w  = '0;
          step_w = step_r + IDX_BITS'(1);
          if (step_r == IDX_BITS'(STEPS - 1)) begin
            state_w = S_IDLE;
            step_w  = '0;
            done_w  = 1'b1;
          end
        end else begin
          gap_w = gap_r + CNT_BITS'(1);
        end
      end
      default: state_w = S_IDLE;
    endcase

    busy_w = (state_w == S_ROLL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      out_r   <= '0;
      gap_r   <= '0;
      step_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_w;
      out_r   <= out_w;
      gap_r   <= gap_w;
      step_r  <= step_w;
      busy_r  <= busy_w;
      done_r  <= done_w;
    end
  end

  assign o_random_out = out_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;

endmodule

// File: doc/lfsr_roller.md
LFSR_ROLLER -- requirements
Module: lfsr_roller

Interface
REQ-001 Parameter WIDTH, default 4: output/seed width in bits (legal: 2..32).
REQ-002 Parameter TAPS, default 4'b1001: feedback mask, WIDTH bits (new MSB = XOR of state bits where TAPS is 1).
REQ-003 Parameter STEPS, default 6: number of output updates per roll (legal: 1..64).
REQ-004 Parameter BASE_GAP, default 2**23: cycles in the first update gap (legal: >=1).
REQ-005 i_clk  input  1  sole clock; all logic on rising edge.
REQ-006 i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_start  input  1  start/restart a roll; sampled every cycle.
REQ-008 i_stop  input  1  abort the current roll and freeze the output.
REQ-009 o_random_out  output  WIDTH  displayed random value, registered.
REQ-010 o_busy  output  1  high while state is ROLL, registered.
REQ-011 o_done  output  1  one-cycle pulse when a roll ends (completion or abort), registered.

Function
REQ-012 The seed register shall advance once every cycle in every state: seed <= {^(seed & TAPS), seed[WIDTH-1:1]}.
REQ-013 The FSM shall have exactly two states, IDLE and ROLL.
REQ-014 In IDLE with i_start=1, the block shall load o_random_out <= current seed, clear the gap counter, clear the step index, and go to ROLL.
REQ-015 In IDLE with i_start=0, o_random_out shall hold its value, and i_stop shall be ignored.
REQ-016 In ROLL, the gap counter shall increment every cycle; step k (k=0..STEPS-1) fires when the counter reaches BASE_GAP*(k+1)-1.
REQ-017 On each fired step:
- o_random_out shall advance by the REQ-012 function applied to o_random_out (not to the seed);
- the gap counter shall clear;
- the step index shall increment.
REQ-018 Gap arithmetic: the gap counter and comparand shall be wide enough for BASE_GAP*STEPS with no wrap; the step index shall be $clog2(STEPS+1) bits.
REQ-019 On the edge that fires step STEPS-1, the state shall return to IDLE and o_done shall be set for exactly the next cycle.
REQ-020 Abort: in ROLL with i_stop=1 and i_start=0, the block shall go to IDLE, hold o_random_out, and pulse o_done.
REQ-021 Restart: i_start=1 in ROLL shall behave as REQ-014 (reload from seed, counters cleared, stay ROLL), and shall take priority over i_stop and over a step firing that cycle; no o_done is issued.
REQ-022 Latency: with i_start sampled at edge E0, o_busy shall be 1 from E0 until the final step edge, and updates shall occur at E0+BASE_GAP*k*(k+1)/2 for k=1..STEPS.
REQ-023 A nonzero seed with a TAPS mask that includes bit 0 shall never produce an all-zero o_random_out.

Reset
REQ-024 Reset shall take effect asynchronously on i_rst_n low and release synchronously on the next clock edge.
REQ-025 Reset values:
- o_random_out = 0;
- o_busy = 0;
- o_done = 0;
- state = IDLE;
- gap counter = 0;
- step index = 0;
- seed = all ones.
REQ-026 Reset asserted mid-roll shall abort the roll immediately, with no o_done pulse.

Structure
REQ-027 Package lfsr_roller_pkg shall hold the state enum (S_IDLE, S_ROLL) and a function lfsr_next(state, taps) used for both the seed register and the output update.
REQ-028 The free-running seed register shall be sub-module lfsr_core (parameters WIDTH, TAPS, RESET_VAL; ports clock, reset, state output).
REQ-029 Each register shall have a single _r/_w pair, with one always_comb block and one always_ff block per module.

Verification (WIDTH=4, TAPS=4'b1001, STEPS=3, BASE_GAP=2 unless noted)
REQ-030 Reset, then i_start pulse on the first edge (seed=F) -> o_random_out = F, 7, B, 5 at E0, E0+2, E0+6, E0+12; o_done high for one cycle after E0+12; o_busy low thereafter.
REQ-031 Idle free-run: i_start delayed 2 cycles after reset (seed=B) -> o_random_out loads B at E0, then 5 at E0+2.
REQ-032 i_stop at E0+4 -> o_random_out frozen at 7, o_done pulses once, o_busy drops, and no later update occurs.
REQ-033 i_start and i_stop both high at E0+6 -> restart from the current seed with no o_done; the next update occurs 2 cycles later.
REQ-034 i_rst_n low at E0+3 -> all outputs 0 immediately; after release, seed = F and the FSM is in IDLE.
REQ-035 Default parameters, 10^5 random start/stop pulses -> o_random_out never equals 0 after the first load; o_done count equals the number of completed plus aborted rolls.
